// File: rtl/priority_code_decoder.sv
// rtl/priority_code_decoder.sv - priority code legality check, binary index conversion, result FIFO
//
// Decodes the (N+1)-bit priority code word into {idx, none, err}. Each accepted
// word is queued in a DEPTH-entry valid/ready FIFO for downstream logic.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   in_code    in   priority code word (bit k = input k-1 highest, bit 0 = none)
//   in_valid   in   in_code presented this cycle
//   in_ready   out  FIFO has room (count < DEPTH)
//   out_idx    out  binary index of the head entry
//   out_none   out  head entry came from the "no input set" code
//   out_err    out  head entry came from an illegal (not one-hot) code
//   out_valid  out  FIFO head is valid
//   out_ready  in   consumer takes the head entry
//   count      out  entries currently held (0..DEPTH)
//   err_clr    in   clears err_cnt (only with PRIO_DEC_ERRCNT_EN)
//   err_cnt    out  saturating count of accepted illegal words (only with PRIO_DEC_ERRCNT_EN)
//
// Optional feature macro: PRIO_DEC_ERRCNT_EN
module priority_code_decoder #(
    parameter  int N     = 6,
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(N + 1),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N:0]    in_code,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_none,
    output logic          out_err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count
`ifdef PRIO_DEC_ERRCNT_EN
    ,
    input  logic          err_clr,
    output logic [7:0]    err_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = IW + 2;
    localparam logic [IW:0] ONE_BIT = 1;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_out_idx;
    logic          r_out_none;
    logic          r_out_err;

    logic [IW:0]   w_ones;
    logic [IW-1:0] w_hi;
    logic          w_none;
    logic          w_err;
    logic [EW-1:0] w_entry;
    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_rd_next;
    logic [CW-1:0] w_cnt_next;
    logic [EW-1:0] w_head_next;

    // Population count and highest set bit; a zero code leaves w_hi at 0.
    always_comb begin
        w_ones = '0;
        w_hi   = '0;
        for (int k = 0; k <= N; k++) begin
            if (in_code[k]) begin
                w_ones = w_ones + ONE_BIT;
                w_hi   = IW'(k);
            end
        end
    end

    assign w_none  = (in_code == (N + 1)'(1));
    assign w_err   = (w_ones != ONE_BIT);
    assign w_entry = {w_hi, w_none, w_err};

    assign w_in_ready = (r_count < CW'(DEPTH));
    assign w_push     = in_valid & w_in_ready;
    assign w_pop      = (r_count != '0) & out_ready;
    assign w_rd_next  = r_rd_ptr + PW'(w_pop);
    assign w_cnt_next = r_count + CW'(w_push) - CW'(w_pop);

    // Next head: when the FIFO is (or is draining to) empty and a word arrives,
    // that word bypasses storage into the output register; otherwise the
    // stored entry at the next read pointer becomes the head.
    always_comb begin
        w_head_next = {r_out_idx, r_out_none, r_out_err};
        if (w_cnt_next != '0) begin
            if (w_push && (r_count == CW'(w_pop))) begin
                w_head_next = w_entry;
            end else begin
                w_head_next = r_mem[w_rd_next];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_idx  <= '0;
            r_out_none <= 1'b0;
            r_out_err  <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + PW'(w_push);
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_cnt_next;
            r_out_idx  <= w_head_next[EW-1:2];
            r_out_none <= w_head_next[1];
            r_out_err  <= w_head_next[0];
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_count != '0);
    assign out_idx   = r_out_idx;
    assign out_none  = r_out_none;
    assign out_err   = r_out_err;
    assign count     = r_count;

`ifdef PRIO_DEC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Clear takes precedence over a same-cycle increment; saturates at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_push && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_priority_code_decoder.sv
// tb/tb_priority_code_decoder.sv - self-checking bench for priority_code_decoder
module tb_priority_code_decoder;

    localparam int N     = 6;
    localparam int DEPTH = 4;
    localparam int IW    = 3;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N:0]    in_code = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] out_idx;
    logic          out_none;
    logic          out_err;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          err_clr = 1'b0;
    logic [7:0]    err_cnt;

    priority_code_decoder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef PRIO_DEC_ERRCNT_EN
        ,
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
`endif
    );

`ifndef PRIO_DEC_ERRCNT_EN
    assign err_cnt = 8'd0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int idx;
        int none;
        int err;
    } ent_t;

    ent_t q[$];
    ent_t last = '{0, 0, 0};
    int   m_errcnt = 0;
    bit   m_push;
    bit   m_pop;
    ent_t m_ent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the code-word rules.
    function automatic ent_t ref_decode(input logic [N:0] c);
        ent_t e;
        int   hi;
        hi = 0;
        for (int k = 0; k <= N; k++) if (c[k]) hi = k;
        e.idx  = hi;
        e.none = (c == 7'b0000001) ? 1 : 0;
        e.err  = ($countones(c) == 1) ? 0 : 1;
        return e;
    endfunction

    // Queue model of the FIFO, updated on each active edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            last     = '{0, 0, 0};
            m_errcnt = 0;
        end else begin
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = out_ready && (q.size() > 0);
            m_ent  = ref_decode(in_code);
            if (m_pop) last = q.pop_front();
            if (m_push) q.push_back(m_ent);
`ifdef PRIO_DEC_ERRCNT_EN
            if (err_clr) m_errcnt = 0;
            else if (m_push && m_ent.err == 1 && m_errcnt < 255) m_errcnt++;
`endif
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        ent_t h;
        if (!reset) begin
            h = (q.size() > 0) ? q[0] : last;
            check("count", 32'(count), 32'(q.size()));
            check("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) ? 1 : 0));
            check("out_valid", 32'(out_valid), 32'((q.size() > 0) ? 1 : 0));
            check("out_idx", 32'(out_idx), 32'(h.idx));
            check("out_none", 32'(out_none), 32'(h.none));
            check("out_err", 32'(out_err), 32'(h.err));
`ifdef PRIO_DEC_ERRCNT_EN
            check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N:0] c4 [5];
    int         e4 [4];

    initial begin
        c4 = '{7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0100000};
        e4 = '{2, 3, 4, 5};

        // Reset state
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_idx", 32'(out_idx), 0);
        check("rst_out_none", 32'(out_none), 0);
        check("rst_out_err", 32'(out_err), 0);
        step();
        step();
        reset = 1'b0;

        // 1: legal codes, highest input then "none"
        in_valid = 1'b1;
        in_code  = 7'b1000000;
        step();
        in_code = 7'b0000001;
        step();
        in_valid = 1'b0;
        check("t1_count", 32'(count), 2);
        check("t1_idx6", 32'(out_idx), 6);
        check("t1_none0", 32'(out_none), 0);
        check("t1_err0", 32'(out_err), 0);
        out_ready = 1'b1;
        step();
        check("t1_idx0", 32'(out_idx), 0);
        check("t1_none1", 32'(out_none), 1);
        check("t1_err0b", 32'(out_err), 0);
        step();
        check("t1_empty", 32'(out_valid), 0);
        check("t1_hold_none", 32'(out_none), 1);
        out_ready = 1'b0;

        // 2: one-cycle latency, head stable while stalled
        in_valid = 1'b1;
        in_code  = 7'b0000100;
        step();
        in_valid = 1'b0;
        check("t2_valid", 32'(out_valid), 1);
        check("t2_idx", 32'(out_idx), 2);
        step();
        step();
        check("t2_valid_hold", 32'(out_valid), 1);
        check("t2_idx_hold", 32'(out_idx), 2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 3: illegal codes
        in_valid = 1'b1;
        in_code  = 7'b0000000;
        step();
        in_code = 7'b0101000;
        step();
        in_valid = 1'b0;
        check("t3_err_a", 32'(out_err), 1);
        check("t3_idx_a", 32'(out_idx), 0);
        check("t3_none_a", 32'(out_none), 0);
`ifdef PRIO_DEC_ERRCNT_EN
        check("t3_err_cnt", 32'(err_cnt), 2);
`endif
        out_ready = 1'b1;
        step();
        check("t3_err_b", 32'(out_err), 1);
        check("t3_idx_b", 32'(out_idx), 5);
        step();
        out_ready = 1'b0;

        // 4/5: fill, refuse 5th, pop-only when full, retry, drain in order
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_code = c4[i];
            step();
        end
        in_code = c4[4];
        step();
        check("t4_count_full", 32'(count), 4);
        check("t4_in_ready", 32'(in_ready), 0);
        check("t4_head", 32'(out_idx), 1);
        out_ready = 1'b1;
        step();
        check("t5_count", 32'(count), 3);
        check("t5_in_ready", 32'(in_ready), 1);
        check("t5_head", 32'(out_idx), 2);
        out_ready = 1'b0;
        step();
        check("t4_retry_count", 32'(count), 4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("t4_order", 32'(out_idx), 32'(e4[j]));
            step();
        end
        check("t4_drained", 32'(out_valid), 0);
        check("t4_hold_idx", 32'(out_idx), 5);
        out_ready = 1'b0;

        // 6: reset mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_code = c4[i];
            step();
        end
        in_valid = 1'b0;
        check("t6_count3", 32'(count), 3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_count0", 32'(count), 0);
        check("t6_valid0", 32'(out_valid), 0);
        check("t6_ready1", 32'(in_ready), 1);
        step();
        reset = 1'b0;

        // Randomised traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 2) == 0) in_code = 7'($urandom);
            else in_code = 7'(1 << $urandom_range(0, N));
            if (((i / 200) % 2) == 1) out_ready = ($urandom_range(0, 99) < 80);
            else out_ready = ($urandom_range(0, 99) < 30);
            err_clr = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid = 1'b0;
        err_clr  = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
